burst_framer: RTL and testbench

Frame delimiter placed directly downstream of the single-channel short FIFO. It consumes the FIFO's read-enable/data pair as a word stream, where a frame is any contiguous run of enabled cycles. It re-emits each word with start-of-frame and end-of-frame tags, truncates frames longer than `MAX_LEN`, and reports each frame's length and truncation status to the capture/control logic.

---
 rtl/burst_framer.sv | 162 ++++++++++++++++
 tb/tb_burst_framer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_framer.sv
// Frame delimiter for the short-FIFO read stream: tags sof/eof, truncates frames
// at MAX_LEN and reports frame length, truncation and discarded-word count.
module burst_framer #(
  parameter int unsigned     DW      = 27,
  parameter int unsigned     CW      = 13,
  parameter logic [CW-1:0]   MAX_LEN = CW'(4300)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          frst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dvld,
  output logic          sof,
  output logic          eof,
  output logic [CW-1:0] len,
  output logic          len_vld,
  output logic          trunc,
  output logic [CW-1:0] drop_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = MAX_LEN - CW'(1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  // Lookahead stage: holds one word until we know whether it ends the frame.
  logic          stg_vld, stg_vld_n;
  logic [DW-1:0] stg_data, stg_data_n;
  logic          stg_first, stg_first_n;
  logic          stg_trunc, stg_trunc_n;

  logic [DW-1:0] dout_n;
  logic          dvld_n, sof_n, eof_n, len_vld_n, trunc_n;
  logic [CW-1:0] len_n, drop_cnt_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stg_vld_n   = 1'b0;
    stg_data_n  = stg_data;
    stg_first_n = stg_first;
    stg_trunc_n = stg_trunc;
    dout_n      = '0;
    dvld_n      = 1'b0;
    sof_n       = 1'b0;
    eof_n       = 1'b0;
    len_vld_n   = 1'b0;
    trunc_n     = 1'b0;
    len_n       = len;
    drop_cnt_n  = drop_cnt;

    if (frst) begin
      // Abort: pending word dies, en is ignored, len/drop_cnt hold.
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      if (stg_vld) begin
        dvld_n = 1'b1;
        dout_n = stg_data;
        sof_n  = stg_first;
        eof_n  = stg_trunc | ~en;
        if (eof_n) begin
          len_vld_n = 1'b1;
          len_n     = cnt;
          trunc_n   = stg_trunc;
        end
      end

      case (state)
        S_IDLE: begin
          if (en) begin
            stg_vld_n   = 1'b1;
            stg_data_n  = din;
            stg_first_n = 1'b1;
            stg_trunc_n = 1'b0;
            cnt_n       = CW'(1);
            state_n     = S_RUN;
          end
        end
        S_RUN: begin
          if (en) begin
            stg_vld_n   = 1'b1;
            stg_data_n  = din;
            stg_first_n = 1'b0;
            if (cnt == LAST_CNT) begin
              stg_trunc_n = 1'b1;
              cnt_n       = MAX_LEN;
              drop_cnt_n  = '0;
              state_n     = S_DROP;
            end else begin
              stg_trunc_n = 1'b0;
              cnt_n       = cnt + CW'(1);
            end
          end else begin
            state_n = S_IDLE;
          end
        end
        S_DROP: begin
          if (en) begin
            if (drop_cnt != CNT_SAT) begin
              drop_cnt_n = drop_cnt + CW'(1);
            end
          end else begin
            state_n = S_IDLE;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      stg_vld   <= 1'b0;
      stg_data  <= '0;
      stg_first <= 1'b0;
      stg_trunc <= 1'b0;
      dout      <= '0;
      dvld      <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      len       <= '0;
      len_vld   <= 1'b0;
      trunc     <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      cnt       <= cnt_n;
      stg_vld   <= stg_vld_n;
      stg_data  <= stg_data_n;
      stg_first <= stg_first_n;
      stg_trunc <= stg_trunc_n;
      dout      <= dout_n;
      dvld      <= dvld_n;
      sof       <= sof_n;
      eof       <= eof_n;
      len       <= len_n;
      len_vld   <= len_vld_n;
      trunc     <= trunc_n;
      drop_cnt  <= drop_cnt_n;
    end
  end

endmodule

// File: tb/tb_burst_framer.sv
// Randomized scoreboard bench for burst_framer with a run-level reference model.
module tb_burst_framer;

  localparam int unsigned DW   = 27;
  localparam int unsigned CW   = 4;
  localparam int          MAXL = 4;
  localparam int          DMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          frst = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dvld, sof, eof, len_vld, trunc;
  logic [CW-1:0] len, drop_cnt;

  burst_framer #(.DW(DW), .CW(CW), .MAX_LEN(CW'(MAXL))) dut (
    .CLK(CLK), .RST(RST), .frst(frst), .en(en), .din(din),
    .dout(dout), .dvld(dvld), .sof(sof), .eof(eof), .len(len),
    .len_vld(len_vld), .trunc(trunc), .drop_cnt(drop_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] d;
    bit            sof;
    bit            eof;
    bit            tr;
    int            len;
    int            due;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: position within the current run decides keep/drop;
  // the most recent kept word waits one cycle to learn whether it is last.
  bit            held_v = 1'b0;
  logic [DW-1:0] held_d;
  bit            held_sof, held_tr;
  int            held_len;
  int            pos = 0;
  int            m_drop = 0;
  int            m_len = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic model(input bit f, input bit e, input logic [DW-1:0] d);
    exp_t x;
    if (f) begin
      held_v = 1'b0;
      pos    = 0;
      return;
    end
    if (held_v) begin
      x.d   = held_d;
      x.sof = held_sof;
      x.eof = held_tr || !e;
      x.tr  = held_tr;
      x.len = held_len;
      x.due = cyc + 1;
      sbq.push_back(x);
      if (x.eof) m_len = held_len;
      held_v = 1'b0;
    end
    if (!e) begin
      pos = 0;
    end else if (pos < MAXL) begin
      pos++;
      held_v   = 1'b1;
      held_d   = d;
      held_sof = (pos == 1);
      held_tr  = (pos == MAXL);
      held_len = pos;
      if (held_tr) m_drop = 0;
    end else if (m_drop < DMAX) begin
      m_drop++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit f, input bit e, input logic [DW-1:0] d);
    frst = f;
    en   = e;
    din  = d;
    model(f, e, d);
    @(posedge CLK);
    #1;
  endtask

  task automatic word();
    step(1'b0, 1'b1, DW'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) word();
  endtask

  // Reset raised in the second half of the current cycle; that cycle's input is lost.
  task automatic mid_reset();
    frst = 1'b0;
    en   = 1'b1;
    din  = DW'($urandom);
    held_v = 1'b0;
    pos    = 0;
    m_drop = 0;
    m_len  = 0;
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("rst_dvld", int'(dvld), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_len", int'(len), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic quiet_check(input string tag);
    idle(4);
    chk({tag, "_len"}, int'(len), m_len);
    chk({tag, "_drop"}, int'(drop_cnt), m_drop);
    chk({tag, "_pending"}, sbq.size(), 0);
  endtask

  // Monitor: pops one expectation per emitted word and checks value and arrival cycle.
  always @(negedge CLK) begin : monitor
    exp_t x;
    if (!RST) begin
      if (dvld) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word dout=%h cycle=%0d", dout, cyc);
        end else begin
          x = sbq.pop_front();
          if (dout !== x.d || sof !== x.sof || eof !== x.eof || len_vld !== x.eof ||
              trunc !== (x.eof && x.tr) || (x.eof && len !== CW'(x.len)) || cyc != x.due) begin
            miscompares++;
            $display("FAIL word actual d=%h sof=%b eof=%b lv=%b tr=%b len=%0d cyc=%0d required d=%h sof=%b eof=%b tr=%b len=%0d cyc=%0d",
                     dout, sof, eof, len_vld, trunc, len, cyc, x.d, x.sof, x.eof, x.tr, x.len, x.due);
          end
        end
      end else begin
        vectors++;
        if (dout != '0 || sof || eof || len_vld || trunc) begin
          miscompares++;
          $display("FAIL idle_outputs actual dout=%h sof=%b eof=%b lv=%b tr=%b required all 0",
                   dout, sof, eof, len_vld, trunc);
        end
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          x = sbq.pop_front();
          miscompares++;
          $display("FAIL missing_word actual dvld=0 required d=%h at cycle %0d", x.d, x.due);
        end
      end
    end
  end

  initial begin
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("reset_dvld", int'(dvld), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_sof", int'(sof), 0);
    chk("reset_eof", int'(eof), 0);
    chk("reset_len", int'(len), 0);
    chk("reset_len_vld", int'(len_vld), 0);
    chk("reset_trunc", int'(trunc), 0);
    chk("reset_drop", int'(drop_cnt), 0);
    RST = 1'b0;
    idle(2);

    run(3);                 quiet_check("three_word");
    run(1);                 quiet_check("single_word");
    run(2); idle(1); run(2); quiet_check("two_frames");
    run(7);                 quiet_check("truncate");
    chk("truncate_drop_is_3", int'(drop_cnt), 3);
    run(2); step(1'b1, 1'b1, DW'($urandom)); run(2); quiet_check("abort");
    run(MAXL);              quiet_check("exact_max");
    run(MAXL - 1);          quiet_check("max_minus_one");
    run(3); mid_reset(); run(2); quiet_check("mid_reset");
    chk("mid_reset_len_is_2", int'(len), 2);
    run(30);                quiet_check("drop_saturate");
    chk("drop_saturated", int'(drop_cnt), DMAX);
    step(1'b1, 1'b0, '0);   quiet_check("idle_abort");

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, DW'($urandom));
      end
    end
    quiet_check("random_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
